// File: rtl/alu_seq_param_if.sv
// Operand/result bundle between the control unit (master) and the sequential ALU (slave).
// Master drives IN_VALID/operands/SELECT; the ALU returns IN_READY, the result and the flags.
interface alu_seq_param_if #(parameter int WIDTH = 8);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [2:0]       SELECT;
    logic             OUT_VALID;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             CARRY;
    logic             ILLEGAL;

    modport master (
        output IN_VALID, DATA1, DATA2, SELECT,
        input  IN_READY, OUT_VALID, RESULT, ZERO, CARRY, ILLEGAL
    );

    modport slave (
        input  IN_VALID, DATA1, DATA2, SELECT,
        output IN_READY, OUT_VALID, RESULT, ZERO, CARRY, ILLEGAL
    );
endinterface

// File: rtl/alu_seq_param.sv
// Sequential ALU: FWD/ADD/AND/OR/SUB, bit-serial SLL/SRA, shift-add MUL (built only with ALU_SEQ_MUL_EN).
// Latency 2 cycles (shifts 2+n, MUL 1+WIDTH) from accept edge to the OUT_VALID pulse.
// IN_READY is high only in IDLE; IN_VALID while busy is dropped, never queued.
module alu_seq_param #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input logic         CLK,
    input logic         RESET,
    alu_seq_param_if.slave alu
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t             state;
    logic               ready_q;
    logic               out_vld_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               illegal_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic [WIDTH-1:0]   res_nxt;
    logic               carry_nxt;
    logic               illegal_nxt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHAMT_W-1:0] MUL_STEPS = SHAMT_W'(WIDTH - 1);
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_nxt;

    // b_q doubles as the multiplier and shifts right one bit per step.
    assign prod_nxt = acc_q + (b_q[0] ? mcand_q : '0);
`endif

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res_nxt     = '0;
        carry_nxt   = 1'b0;
        illegal_nxt = 1'b0;
        case (op_q)
            OP_FWD: res_nxt = b_q;
            OP_ADD: {carry_nxt, res_nxt} = sum;
            OP_AND: res_nxt = a_q & b_q;
            OP_OR:  res_nxt = a_q | b_q;
            OP_SUB: begin
                res_nxt   = diff[WIDTH-1:0];
                carry_nxt = ~diff[WIDTH];
            end
            OP_SLL: res_nxt = a_q;
            OP_SRA: res_nxt = a_q;
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                res_nxt   = prod_nxt[WIDTH-1:0];
                carry_nxt = |prod_nxt[2*WIDTH-1:WIDTH];
`else
                illegal_nxt = 1'b1;
`endif
            end
            default: res_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            out_vld_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_FWD;
            cnt_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
`endif
        end else begin
            out_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (alu.IN_VALID) begin
                        a_q     <= alu.DATA1;
                        b_q     <= alu.DATA2;
                        op_q    <= alu.SELECT;
                        state   <= EXEC;
                        ready_q <= 1'b0;
                        if (alu.SELECT == OP_SLL || alu.SELECT == OP_SRA)
                            cnt_q <= alu.DATA2[SHAMT_W-1:0];
`ifdef ALU_SEQ_MUL_EN
                        else if (alu.SELECT == OP_MUL)
                            cnt_q <= MUL_STEPS;
`endif
                        else
                            cnt_q <= '0;
`ifdef ALU_SEQ_MUL_EN
                        acc_q   <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, alu.DATA1};
`endif
                    end
                end
                EXEC: begin
`ifdef ALU_SEQ_MUL_EN
                    // MUL steps on every EXEC cycle, including the last one.
                    if (op_q == OP_MUL) begin
                        acc_q   <= prod_nxt;
                        mcand_q <= mcand_q << 1;
                        b_q     <= b_q >> 1;
                    end
`endif
                    if (cnt_q == '0) begin
                        state     <= DONE;
                        out_vld_q <= 1'b1;
                        result_q  <= res_nxt;
                        zero_q    <= (res_nxt == '0);
                        carry_q   <= carry_nxt;
                        illegal_q <= illegal_nxt;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (op_q == OP_SLL)
                            a_q <= a_q << 1;
                        else if (op_q == OP_SRA)
                            a_q <= {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign alu.IN_READY  = ready_q;
    assign alu.OUT_VALID = out_vld_q;
    assign alu.RESULT    = result_q;
    assign alu.ZERO      = zero_q;
    assign alu.CARRY     = carry_q;
    assign alu.ILLEGAL   = illegal_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param (WIDTH=8); expected MUL behaviour follows ALU_SEQ_MUL_EN.
module tb_alu_seq_param;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_param_if #(.WIDTH(W)) bus ();

    alu_seq_param #(.WIDTH(W), .SHAMT_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .alu   (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         carry;
        logic         illegal;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0]     wide;
        logic [2*W-1:0] prod;
        e.res = '0; e.carry = 1'b0; e.illegal = 1'b0; e.lat = 2; e.acc_cyc = 0;
        case (op)
            3'b000: e.res = b;
            3'b001: begin wide = a + b; e.res = wide[W-1:0]; e.carry = wide[W]; end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: begin e.res = a - b; e.carry = (a >= b); end
            3'b101: begin e.res = a << b[2:0]; e.lat = 2 + int'(b[2:0]); end
            3'b110: begin e.res = $signed(a) >>> b[2:0]; e.lat = 2 + int'(b[2:0]); end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                prod = a * b;
                e.res = prod[W-1:0];
                e.carry = |prod[2*W-1:W];
                e.lat = 1 + W;
`else
                prod = '0;
                e.illegal = 1'b1;
`endif
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Output monitor: every OUT_VALID pulse must match the oldest expected entry.
    always @(negedge CLK) begin
        if (!RESET && bus.OUT_VALID) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",  bus.RESULT,  e.res);
                check("zero",    bus.ZERO,    e.zero);
                check("carry",   bus.CARRY,   e.carry);
                check("illegal", bus.ILLEGAL, e.illegal);
                check("latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n = 0;
        @(negedge CLK);
        while (!bus.IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.IN_READY) check("ready_timeout", 0, 1);
        bus.IN_VALID = 1'b1;
        bus.SELECT   = op;
        bus.DATA1    = a;
        bus.DATA2    = b;
        e = model(op, a, b);
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        bus.DATA1    = W'($urandom);
        bus.DATA2    = W'($urandom);
        bus.SELECT   = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"},  bus.RESULT,    0);
        check({tag, "_zero"},    bus.ZERO,      0);
        check({tag, "_carry"},   bus.CARRY,     0);
        check({tag, "_illegal"}, bus.ILLEGAL,   0);
        check({tag, "_outvld"},  bus.OUT_VALID, 0);
        check({tag, "_ready"},   bus.IN_READY,  1);
    endtask

    initial begin
        int busy;
        RESET = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.DATA1 = '0;
        bus.DATA2 = '0;
        bus.SELECT = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_cleared("reset");

        send(3'b001, 8'h8F, 8'h71);
        drain();
        send(3'b100, 8'h05, 8'h09);
        drain();

        // SRA by 3 with IN_VALID pulses while busy that must be ignored.
        send(3'b110, 8'h90, 8'h03);
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.IN_READY) break;
            busy++;
            bus.IN_VALID = 1'b1;
            bus.SELECT   = 3'b001;
            bus.DATA1    = W'($urandom);
            bus.DATA2    = W'($urandom);
        end
        bus.IN_VALID = 1'b0;
        check("sra_busy_cycles", busy, 5);
        drain();

        send(3'b111, 8'h12, 8'h10);
        drain();
        send(3'b000, 8'h00, 8'hA5);
        send(3'b010, 8'hF0, 8'h3C);
        send(3'b011, 8'h00, 8'h00);
        send(3'b101, 8'h81, 8'h00);
        send(3'b101, 8'h01, 8'h07);
        send(3'b110, 8'h7F, 8'h07);
        send(3'b100, 8'h33, 8'h33);
        send(3'b111, 8'hFF, 8'hFF);
        drain();

        for (int i = 0; i < 40; i++)
            send(3'($urandom), W'($urandom), W'($urandom));
        drain();

        // Abort a long operation on its 4th EXEC cycle.
`ifdef ALU_SEQ_MUL_EN
        send(3'b111, 8'h12, 8'h10);
`else
        send(3'b101, 8'h01, 8'h07);
`endif
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        sb.delete();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_cleared("abort");
        repeat (12) @(negedge CLK);
        check("abort_no_out_valid", bus.OUT_VALID, 0);

        send(3'b001, 8'h01, 8'h02);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
